// File: rtl/bneck_act_pkg.sv
// Shared types and Q8.8 constants for the bneck activation stage.
package bneck_act_pkg;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_RELU6  = 2'd2,
    ACT_HSWISH = 2'd3
  } act_mode_t;

  localparam logic signed [15:0] Q_THREE = 16'sh0300;
  localparam logic signed [15:0] Q_SIX   = 16'sh0600;
  localparam int INV6_Q16  = 10923;
  localparam int HSW_SHIFT = 24;

endpackage

// File: rtl/bneck_activation_if.sv
// Stream bus between BN, the activation stage and its downstream consumer.
interface bneck_activation_if #(
  parameter int WIDTH = 16,
  parameter int CH_W  = 4
);
  logic             en;
  logic [WIDTH-1:0] x_in;
  logic [CH_W-1:0]  channel_in;
  logic             valid_in;
  logic [1:0]       act_mode;
  logic [WIDTH-1:0] y_out;
  logic [CH_W-1:0]  channel_out;
  logic             valid_out;
  logic             ready_in;
  logic             overflow;
  logic [15:0]      drop_count;

  modport master (
    output en, x_in, channel_in, valid_in, act_mode, ready_in,
    input  y_out, channel_out, valid_out, overflow, drop_count
  );

  modport slave (
    input  en, x_in, channel_in, valid_in, act_mode, ready_in,
    output y_out, channel_out, valid_out, overflow, drop_count
  );
endinterface

// File: rtl/bneck_out_fifo.sv
// Synchronous FIFO with first-word fall-through head; reads zero when empty.
module bneck_out_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bneck_activation.sv
// Three-stage activation pipeline (NONE/ReLU/ReLU6/h-swish) feeding an output FIFO
// with drop detection, since the BN source cannot be stalled.
module bneck_activation #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int CHANNELS  = 16,
  parameter int OUT_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  bneck_activation_if.slave bus
);
  import bneck_act_pkg::*;

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int FW    = WIDTH + CH_W;
  // HSW_SHIFT is stated for Q8.8; keep the rescale tracking FRAC.
  localparam int SHIFT = HSW_SHIFT + FRAC - 8;
  localparam logic signed [47:0] HSW_K   = 48'(INV6_Q16);
  localparam logic signed [47:0] HSW_RND = 48'sd1 <<< (SHIFT - 1);
  localparam logic signed [47:0] HSW_MAX = 48'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [47:0] HSW_MIN = 48'(-(64'sd1 <<< (WIDTH - 1)));

  logic signed [WIDTH:0]     w_sum;
  logic signed [WIDTH:0]     w_t;
  logic                      r_s1_vld;
  logic signed [WIDTH-1:0]   r_s1_x;
  logic signed [WIDTH:0]     r_s1_t;
  logic [CH_W-1:0]           r_s1_ch;
  act_mode_t                 r_s1_mode;
  logic                      r_s2_vld;
  logic signed [WIDTH-1:0]   r_s2_x;
  logic signed [2*WIDTH-1:0] r_s2_p;
  logic [CH_W-1:0]           r_s2_ch;
  act_mode_t                 r_s2_mode;
  logic                      r_s3_vld;
  logic [WIDTH-1:0]          r_s3_y;
  logic [CH_W-1:0]           r_s3_ch;
  logic signed [47:0]        w_hsw_full;
  logic signed [47:0]        w_hsw;
  logic signed [WIDTH-1:0]   w_y;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_drop;
  logic [FW-1:0]             w_head;
  logic                      r_overflow;
  logic [15:0]               r_drop_cnt;

  assign w_sum = {bus.x_in[WIDTH-1], bus.x_in} + (WIDTH+1)'(Q_THREE);

  always_comb begin
    w_t = w_sum;
    if (w_sum < 0)                             w_t = '0;
    else if (w_sum > (WIDTH+1)'(Q_SIX))        w_t = (WIDTH+1)'(Q_SIX);
  end

  assign w_hsw_full = 48'(r_s2_p) * HSW_K + HSW_RND;
  assign w_hsw      = w_hsw_full >>> SHIFT;

  always_comb begin
    w_y = r_s2_x;
    case (r_s2_mode)
      ACT_RELU:  if (r_s2_x < 0) w_y = '0;
      ACT_RELU6: begin
        if (r_s2_x < 0)                      w_y = '0;
        else if (r_s2_x > WIDTH'(Q_SIX))     w_y = WIDTH'(Q_SIX);
      end
      ACT_HSWISH: begin
        if (w_hsw > HSW_MAX)                 w_y = HSW_MAX[WIDTH-1:0];
        else if (w_hsw < HSW_MIN)            w_y = HSW_MIN[WIDTH-1:0];
        else                                 w_y = w_hsw[WIDTH-1:0];
      end
      default: w_y = r_s2_x;
    endcase
  end

  // The whole pipeline, including the final push, freezes while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_x    <= '0;
      r_s1_t    <= '0;
      r_s1_ch   <= '0;
      r_s1_mode <= ACT_NONE;
      r_s2_vld  <= 1'b0;
      r_s2_x    <= '0;
      r_s2_p    <= '0;
      r_s2_ch   <= '0;
      r_s2_mode <= ACT_NONE;
      r_s3_vld  <= 1'b0;
      r_s3_y    <= '0;
      r_s3_ch   <= '0;
    end else if (bus.en) begin
      r_s1_vld <= bus.valid_in;
      if (bus.valid_in) begin
        r_s1_x    <= bus.x_in;
        r_s1_t    <= w_t;
        r_s1_ch   <= bus.channel_in;
        r_s1_mode <= act_mode_t'(bus.act_mode);
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_x    <= r_s1_x;
      r_s2_p    <= (2*WIDTH)'(r_s1_x) * (2*WIDTH)'(r_s1_t);
      r_s2_ch   <= r_s1_ch;
      r_s2_mode <= r_s1_mode;
      r_s3_vld  <= r_s2_vld;
      r_s3_y    <= w_y;
      r_s3_ch   <= r_s2_ch;
    end
  end

  assign w_push = r_s3_vld & bus.en;
  assign w_pop  = bus.ready_in & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  bneck_out_fifo #(.W(FW), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_s3_y, r_s3_ch}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.y_out       = w_head[FW-1:CH_W];
  assign bus.channel_out = w_head[CH_W-1:0];
  assign bus.valid_out   = ~w_empty;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_cnt;

endmodule
